// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between two requesters:
// port 0 (ALU result) and port 1 (memory load data). Ties are broken
// round-robin. The winning write is registered onto the register file's
// WriteEnable/WriteSelect/WriteData inputs. Read-after-write hazards on the
// two read selects are flagged so the datapath can forward the pending data.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   hold                       stall; no request is accepted while high
//   reqN_valid/sel/data        write request from port N (N = 0, 1)
//   reqN_ready                 combinational grant to port N
//   WriteEnable/Select/Data    registered write to the register file
//   ReadSelect1/2              register file read selects (hazard check)
//   fwd_hit1/2                 pending write targets ReadSelect1/2
//   fwd_data                   forwarding source (equals WriteData)
//
// Handshake: a transfer on port N happens at a rising clock edge where
// reqN_valid and reqN_ready are both high. reqN_ready never depends on
// anything other than hold, both valids and the round-robin pointer, and
// at most one ready is high in any cycle. A requester holds valid, sel and
// data stable until its transfer.
module regfile_wb_arbiter #(
   parameter int BITSIZE = 64,
   parameter int REGSIZE = 32,
   parameter int ZEROREG = 31,
   localparam int SW = $clog2(REGSIZE)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic               req0_valid,
   input  logic [SW-1:0]      req0_sel,
   input  logic [BITSIZE-1:0] req0_data,
   input  logic               req1_valid,
   input  logic [SW-1:0]      req1_sel,
   input  logic [BITSIZE-1:0] req1_data,
   output logic               req0_ready,
   output logic               req1_ready,
   output logic               WriteEnable,
   output logic [SW-1:0]      WriteSelect,
   output logic [BITSIZE-1:0] WriteData,
   input  logic [SW-1:0]      ReadSelect1,
   input  logic [SW-1:0]      ReadSelect2,
   output logic               fwd_hit1,
   output logic               fwd_hit2,
   output logic [BITSIZE-1:0] fwd_data
);

   localparam logic [SW-1:0] ZERO_SEL = SW'(ZEROREG);

   // last_q: index of the most recently granted port.
   logic               last_q, last_d;
   logic               we_q, we_d;
   logic [SW-1:0]      ws_q, ws_d;
   logic [BITSIZE-1:0] wd_q, wd_d;
   logic               gnt0, gnt1;

   // On a tie the port that did not win last time is granted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!hold) begin
         if (req0_valid && req1_valid) begin
            if (last_q) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
         end else if (req0_valid) begin
            gnt0 = 1'b1;
         end else if (req1_valid) begin
            gnt1 = 1'b1;
         end
      end
   end

   // A transfer to the zero register still consumes the slot and moves the
   // pointer, but never raises the write strobe.
   always_comb begin
      last_d = last_q;
      we_d   = 1'b0;
      ws_d   = ws_q;
      wd_d   = wd_q;
      if (gnt0 && req0_valid) begin
         last_d = 1'b0;
         ws_d   = req0_sel;
         wd_d   = req0_data;
         we_d   = (req0_sel != ZERO_SEL);
      end else if (gnt1 && req1_valid) begin
         last_d = 1'b1;
         ws_d   = req1_sel;
         wd_d   = req1_data;
         we_d   = (req1_sel != ZERO_SEL);
      end
   end

   // Reset leaves last_q=1 so port 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
         we_q   <= 1'b0;
         ws_q   <= '0;
         wd_q   <= '0;
      end else begin
         last_q <= last_d;
         we_q   <= we_d;
         ws_q   <= ws_d;
         wd_q   <= wd_d;
      end
   end

   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign WriteEnable = we_q;
   assign WriteSelect = ws_q;
   assign WriteData   = wd_q;

   // The register file returns the old value during the cycle the write is
   // pending, so a matching read select must take fwd_data instead.
   assign fwd_hit1 = we_q && (ws_q == ReadSelect1);
   assign fwd_hit2 = we_q && (ws_q == ReadSelect2);
   assign fwd_data = wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

   localparam int BW = 64;
   localparam int SW = 5;
   localparam int EW = SW + BW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          hold = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [SW-1:0] req0_sel = '0, req1_sel = '0;
   logic [BW-1:0] req0_data = '0, req1_data = '0;
   logic          req0_ready, req1_ready;
   logic          WriteEnable;
   logic [SW-1:0] WriteSelect;
   logic [BW-1:0] WriteData;
   logic [SW-1:0] ReadSelect1 = '0, ReadSelect2 = '0;
   logic          fwd_hit1, fwd_hit2;
   logic [BW-1:0] fwd_data;

   int chk_cnt = 0;
   int pass_cnt = 0;

   logic [EW-1:0] exp_q[$];
   logic [BW-1:0] rf [32];

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req0_valid(req0_valid), .req0_sel(req0_sel), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_sel(req1_sel), .req1_data(req1_data),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .WriteEnable(WriteEnable), .WriteSelect(WriteSelect), .WriteData(WriteData),
      .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout req=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- register file model ----------------
   initial for (int i = 0; i < 32; i++) rf[i] = '0;
   always @(posedge clk) if (WriteEnable) rf[WriteSelect] <= WriteData;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      req0_valid = 1'b0; req1_valid = 1'b0; hold = 1'b0;
   endtask

   // Drive one cycle of stimulus (caller is just past a negedge), check the
   // grant, and queue the write the register file should see.
   task automatic drive_check(input logic v0, input logic [SW-1:0] s0, input logic [BW-1:0] d0,
                              input logic v1, input logic [SW-1:0] s1, input logic [BW-1:0] d1,
                              input logic h, input logic er0, input logic er1);
      req0_valid = v0; req0_sel = s0; req0_data = d0;
      req1_valid = v1; req1_sel = s1; req1_data = d1;
      hold = h;
      #1;
      chk("req0_ready", BW'(req0_ready), BW'(er0));
      chk("req1_ready", BW'(req1_ready), BW'(er1));
      if (er0 && s0 != 5'd31) exp_q.push_back({s0, d0});
      if (er1 && s1 != 5'd31) exp_q.push_back({s1, d1});
   endtask

   task automatic cycle(input logic v0, input logic [SW-1:0] s0, input logic [BW-1:0] d0,
                        input logic v1, input logic [SW-1:0] s1, input logic [BW-1:0] d1,
                        input logic h, input logic er0, input logic er1);
      @(negedge clk);
      drive_check(v0, s0, d0, v1, s1, d1, h, er0, er1);
   endtask

   task automatic idle();
      @(negedge clk);
      set_idle();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_idle();
      rst = 1'b1;
      #1;
      chk("rst_we", BW'(WriteEnable), 0);
      chk("rst_ws", BW'(WriteSelect), 0);
      chk("rst_wd", WriteData, 0);
      chk("rst_fwd", BW'({fwd_hit1, fwd_hit2}), 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always begin
      @(posedge clk);
      #2;
      if (WriteEnable) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", BW'(WriteSelect), BW'(5'd31));
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            chk("wr_sel", BW'(WriteSelect), BW'(e[EW-1:BW]));
            chk("wr_data", WriteData, e[BW-1:0]);
         end
      end
   end

   // ---------------- requester rule checker ----------------
   logic          p0_pend = 1'b0, p1_pend = 1'b0;
   logic [SW-1:0] p0_sel, p1_sel;
   logic [BW-1:0] p0_data, p1_data;
   always begin
      @(negedge clk);
      #4;
      if (p0_pend) chk("req0_stable", BW'({req0_valid, req0_sel}) ^ (req0_data ^ p0_data), BW'({1'b1, p0_sel}));
      if (p1_pend) chk("req1_stable", BW'({req1_valid, req1_sel}) ^ (req1_data ^ p1_data), BW'({1'b1, p1_sel}));
      p0_pend = req0_valid && !(req0_ready && !rst);
      p1_pend = req1_valid && !(req1_ready && !rst);
      p0_sel = req0_sel; p0_data = req0_data;
      p1_sel = req1_sel; p1_data = req1_data;
   end

   // ---------------- directed stimulus ----------------
   initial begin
      do_reset();

      // single write on port 0, visible in the register file one cycle later
      cycle(1, 5'd5, 64'hA5, 0, 5'd0, 64'h0, 0, 1, 0);
      idle();
      idle();
      chk("rf5", rf[5], 64'hA5);

      // sustained tie from reset: grants 0,1,0,1
      do_reset();
      cycle(1, 5'd1, 64'h101, 1, 5'd2, 64'h202, 0, 1, 0);
      cycle(1, 5'd1, 64'h103, 1, 5'd2, 64'h202, 0, 0, 1);
      cycle(1, 5'd1, 64'h103, 1, 5'd2, 64'h204, 0, 1, 0);
      cycle(0, 5'd0, 64'h0,   1, 5'd2, 64'h204, 0, 0, 1);
      idle();

      // zero register: granted, no write strobe
      cycle(0, 5'd0, 64'h0, 1, 5'd31, 64'hFFFF, 0, 0, 1);
      idle();
      chk("zero_we", BW'(WriteEnable), 0);
      idle();
      chk("rf31", rf[31], 64'h0);

      // forwarding window
      ReadSelect1 = 5'd7; ReadSelect2 = 5'd3;
      cycle(1, 5'd7, 64'h1234, 0, 5'd0, 64'h0, 0, 1, 0);
      idle();
      chk("fwd_hit1_on", BW'(fwd_hit1), 1);
      chk("fwd_hit2_on", BW'(fwd_hit2), 0);
      chk("fwd_data", fwd_data, 64'h1234);
      idle();
      chk("fwd_hit1_off", BW'(fwd_hit1), 0);
      chk("fwd_hit2_off", BW'(fwd_hit2), 0);
      ReadSelect1 = '0; ReadSelect2 = '0;

      // hold rising right after a grant: registered write completes
      cycle(1, 5'd4, 64'h44, 0, 5'd0, 64'h0, 0, 1, 0);
      cycle(0, 5'd0, 64'h0, 1, 5'd6, 64'h66, 1, 0, 0);
      chk("hold_we_completes", BW'(WriteEnable), 1);
      cycle(0, 5'd0, 64'h0, 1, 5'd6, 64'h66, 1, 0, 0);
      chk("hold_we_off", BW'(WriteEnable), 0);
      cycle(0, 5'd0, 64'h0, 1, 5'd6, 64'h66, 0, 0, 1);
      idle();

      // hold with both valid from reset, then release: port 0 first
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1, 5'd8, 64'h88, 1, 5'd9, 64'h99, 1, 0, 0);
         chk("hold_we", BW'(WriteEnable), 0);
      end
      cycle(1, 5'd8, 64'h88, 1, 5'd9, 64'h99, 0, 1, 0);
      cycle(0, 5'd0, 64'h0,  1, 5'd9, 64'h99, 0, 0, 1);
      idle();
      idle();

      // reset mid-stream while a write is pending
      rf[11] = '0;
      cycle(1, 5'd11, 64'hBB, 1, 5'd10, 64'hAA, 0, 1, 0);
      @(negedge clk);
      chk("pre_rst_we", BW'(WriteEnable), 1);
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_we", BW'(WriteEnable), 0);
      chk("mid_rst_ws", BW'(WriteSelect), 0);
      chk("mid_rst_wd", WriteData, 0);
      chk("mid_rst_fwd", BW'({fwd_hit1, fwd_hit2}), 0);
      @(negedge clk);
      chk("rf11_no_write", rf[11], 64'h0);
      rst = 1'b0;
      drive_check(1, 5'd12, 64'hCC, 1, 5'd10, 64'hAA, 0, 1, 0);
      cycle(0, 5'd0, 64'h0, 1, 5'd10, 64'hAA, 0, 0, 1);
      idle();
      idle();
      idle();
      chk("rf10", rf[10], 64'hAA);
      chk("rf12", rf[12], 64'hCC);
      chk("queue_empty", BW'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
